// File: rtl/playfield_writer.sv
// CPU write port for the playfield tile RAM: pointer/data registers, auto-increment
// single writes, and a one-entry-per-clock fill engine for screen clears.
module playfield_writer #(
   parameter int          CPU_WIDTH = 12,
   parameter int          PF_AW     = 10,
   parameter int          PF_DW     = 8,
   parameter logic [1:0]  IO_SEL    = 2'h2
) (
   input  logic                 i_Clk,
   input  logic                 i_Reset_n,
   input  logic                 cpu_write,
   input  logic [CPU_WIDTH-1:0] cpu_addr,
   input  logic [CPU_WIDTH-1:0] cpu_wr_data,
   output logic [CPU_WIDTH-1:0] cpu_rd_data,
   output logic                 pf_write,
   output logic [PF_AW-1:0]     pf_write_addr,
   output logic [PF_DW-1:0]     pf_wr_data,
   output logic                 busy
);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   localparam logic [PF_AW:0] MAX_CNT = {1'b1, {PF_AW{1'b0}}};
   localparam logic [PF_AW:0] ONE_CNT = {{PF_AW{1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [PF_AW-1:0]  ptr_q, ptr_d;
   logic [PF_DW-1:0]  fill_val_q, fill_val_d;
   logic [PF_AW:0]    remaining_q, remaining_d;
   logic              error_q, error_d;
   logic              busy_q, busy_d;
   logic              pf_write_q, pf_write_d;
   logic [PF_AW-1:0]  pf_addr_q, pf_addr_d;
   logic [PF_DW-1:0]  pf_data_q, pf_data_d;

   logic              sel;
   logic              reg_wr;
   logic [PF_AW:0]    raw_cnt;
   logic [PF_AW:0]    fill_cnt;
   logic              unused_bits;

   assign sel         = (cpu_addr[CPU_WIDTH-1:CPU_WIDTH-2] == IO_SEL);
   assign reg_wr      = sel & cpu_write;
   assign raw_cnt     = cpu_wr_data[PF_AW:0];
   assign fill_cnt    = (raw_cnt > MAX_CNT) ? MAX_CNT : raw_cnt;
   assign unused_bits = ^{cpu_addr[CPU_WIDTH-3:2], cpu_wr_data[CPU_WIDTH-1:PF_AW+1]};

   // remaining counts writes still to issue after the current one; busy_q covers
   // every cycle that carries a fill write, so the last fill cycle still drops CPU writes.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      fill_val_d  = fill_val_q;
      remaining_d = remaining_q;
      error_d     = error_q;
      busy_d      = 1'b0;
      pf_write_d  = 1'b0;
      pf_addr_d   = pf_addr_q;
      pf_data_d   = pf_data_q;

      if (state_q == S_FILL) begin
         pf_write_d  = 1'b1;
         pf_addr_d   = ptr_q;
         pf_data_d   = fill_val_q;
         ptr_d       = ptr_q + 1'b1;
         remaining_d = remaining_q - 1'b1;
         busy_d      = 1'b1;
         if (remaining_q == ONE_CNT) begin
            state_d = S_IDLE;
         end
      end

      if (reg_wr) begin
         if (busy_q) begin
            error_d = 1'b1;
         end else begin
            case (cpu_addr[1:0])
               2'd0: ptr_d = cpu_wr_data[PF_AW-1:0];
               2'd1: begin
                  pf_write_d = 1'b1;
                  pf_addr_d  = ptr_q;
                  pf_data_d  = cpu_wr_data[PF_DW-1:0];
                  ptr_d      = ptr_q + 1'b1;
               end
               2'd2: begin
                  error_d = 1'b0;
                  if (fill_cnt != '0) begin
                     // The first fill entry is issued on the accepting edge.
                     pf_write_d  = 1'b1;
                     pf_addr_d   = ptr_q;
                     pf_data_d   = fill_val_q;
                     ptr_d       = ptr_q + 1'b1;
                     remaining_d = fill_cnt - 1'b1;
                     busy_d      = 1'b1;
                     state_d     = (fill_cnt == ONE_CNT) ? S_IDLE : S_FILL;
                  end
               end
               default: fill_val_d = cpu_wr_data[PF_DW-1:0];
            endcase
         end
      end
   end

   always_comb begin
      cpu_rd_data = '0;
      if (sel) begin
         cpu_rd_data[CPU_WIDTH-1] = busy_q;
         cpu_rd_data[CPU_WIDTH-2] = error_q;
         cpu_rd_data[PF_AW-1:0]   = ptr_q;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         fill_val_q  <= '0;
         remaining_q <= '0;
         error_q     <= 1'b0;
         busy_q      <= 1'b0;
         pf_write_q  <= 1'b0;
         pf_addr_q   <= '0;
         pf_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         fill_val_q  <= fill_val_d;
         remaining_q <= remaining_d;
         error_q     <= error_d;
         busy_q      <= busy_d;
         pf_write_q  <= pf_write_d;
         pf_addr_q   <= pf_addr_d;
         pf_data_q   <= pf_data_d;
      end
   end

   assign pf_write      = pf_write_q;
   assign pf_write_addr = pf_addr_q;
   assign pf_wr_data    = pf_data_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_playfield_writer.sv
// Bench for playfield_writer: scoreboard of expected RAM writes plus per-scenario tasks.
module tb_playfield_writer;

   localparam logic [11:0] A_PTR  = 12'h800;
   localparam logic [11:0] A_DATA = 12'h801;
   localparam logic [11:0] A_FILL = 12'h802;
   localparam logic [11:0] A_FV   = 12'h803;

   logic        i_Clk = 1'b0;
   logic        i_Reset_n;
   logic        cpu_write;
   logic [11:0] cpu_addr;
   logic [11:0] cpu_wr_data;
   logic [11:0] cpu_rd_data;
   logic        pf_write;
   logic [9:0]  pf_write_addr;
   logic [7:0]  pf_wr_data;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   logic [17:0] exp_q[$];

   playfield_writer #(.CPU_WIDTH(12), .PF_AW(10), .PF_DW(8), .IO_SEL(2'h2)) dut (
      .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
      .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data), .pf_write(pf_write),
      .pf_write_addr(pf_write_addr), .pf_wr_data(pf_wr_data), .busy(busy)
   );

   always #5 i_Clk = ~i_Clk;

   // Scoreboard: every observed RAM write must match the oldest expected one.
   always @(negedge i_Clk) begin
      if (i_Reset_n && pf_write) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL pf_unexpected: got addr=%0h data=%0h, none expected", pf_write_addr, pf_wr_data);
         end else begin
            logic [17:0] e;
            e = exp_q.pop_front();
            if ({pf_write_addr, pf_wr_data} !== e) begin
               n_bad++;
               $display("FAIL pf_write: got addr=%0h data=%0h, want addr=%0h data=%0h",
                        pf_write_addr, pf_wr_data, e[17:8], e[7:0]);
            end
         end
      end
   end

   // Called at a falling edge; the write is sampled on the next rising edge.
   task automatic wr(input logic [11:0] addr, input logic [11:0] data);
      cpu_write   = 1'b1;
      cpu_addr    = addr;
      cpu_wr_data = data;
      @(negedge i_Clk);
      cpu_write   = 1'b0;
      cpu_addr    = A_PTR;
   endtask

   task automatic push(input logic [9:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic test_reset;
      i_Reset_n = 1'b0; cpu_write = 1'b0; cpu_addr = A_PTR; cpu_wr_data = '0;
      repeat (3) @(negedge i_Clk);
      n_cmp++;
      if ({pf_write, pf_write_addr, pf_wr_data, busy, cpu_rd_data} !== 31'h0) begin
         n_bad++;
         $display("FAIL reset_state: got pfw=%0b addr=%0h data=%0h busy=%0b rd=%0h, want all 0",
                  pf_write, pf_write_addr, pf_wr_data, busy, cpu_rd_data);
      end
      i_Reset_n = 1'b1;
      @(negedge i_Clk);
   endtask

   task automatic test_back_to_back;
      wr(A_PTR, 12'd1022);
      push(10'd1022, 8'h11); wr(A_DATA, 12'h011);
      n_cmp++; if (pf_write !== 1'b1) begin n_bad++; $display("FAIL b2b_w1: pf_write=%0b want 1", pf_write); end
      push(10'd1023, 8'h22); wr(A_DATA, 12'h022);
      n_cmp++; if (pf_write !== 1'b1) begin n_bad++; $display("FAIL b2b_w2: pf_write=%0b want 1", pf_write); end
      push(10'd0, 8'h33); wr(A_DATA, 12'h033);
      n_cmp++; if (pf_write !== 1'b1) begin n_bad++; $display("FAIL b2b_w3: pf_write=%0b want 1", pf_write); end
      @(negedge i_Clk);
      n_cmp++; if (pf_write !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: pf_write=%0b want 0", pf_write); end
      n_cmp++; if (cpu_rd_data !== 12'h001) begin n_bad++; $display("FAIL b2b_ptr: rd=%0h want 001", cpu_rd_data); end
   endtask

   task automatic test_fill;
      wr(A_FV, 12'h005);
      wr(A_PTR, 12'h100);
      for (int i = 0; i < 4; i++) push(10'(10'h100 + i), 8'h05);
      wr(A_FILL, 12'd4);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if ({busy, pf_write} !== 2'b11) begin
            n_bad++; $display("FAIL fill_active[%0d]: busy=%0b pfw=%0b want 1 1", i, busy, pf_write);
         end
         @(negedge i_Clk);
      end
      n_cmp++;
      if ({busy, pf_write} !== 2'b00) begin
         n_bad++; $display("FAIL fill_done: busy=%0b pfw=%0b want 0 0", busy, pf_write);
      end
      n_cmp++; if (cpu_rd_data !== 12'h104) begin n_bad++; $display("FAIL fill_ptr: rd=%0h want 104", cpu_rd_data); end
   endtask

   task automatic test_busy_drop;
      wr(A_PTR, 12'h200);
      for (int i = 0; i < 4; i++) push(10'(10'h200 + i), 8'h05);
      wr(A_FILL, 12'd4);
      @(negedge i_Clk);
      wr(A_DATA, 12'h07F);
      repeat (2) @(negedge i_Clk);
      n_cmp++; if (pf_wr_data !== 8'h05) begin n_bad++; $display("FAIL drop_data_held: data=%0h want 05", pf_wr_data); end
      n_cmp++; if (cpu_rd_data !== 12'h604) begin n_bad++; $display("FAIL drop_error: rd=%0h want 604", cpu_rd_data); end
      push(10'h204, 8'h05);
      wr(A_FILL, 12'd1);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL fill1_busy: busy=%0b want 1", busy); end
      @(negedge i_Clk);
      n_cmp++; if (cpu_rd_data !== 12'h205) begin n_bad++; $display("FAIL err_clear: rd=%0h want 205", cpu_rd_data); end
      // Write during the final fill cycle is dropped; the next one is accepted.
      push(10'h205, 8'h05); push(10'h206, 8'h05);
      wr(A_FILL, 12'd2);
      @(negedge i_Clk);
      wr(A_PTR, 12'h000);
      n_cmp++; if (cpu_rd_data !== 12'h607) begin n_bad++; $display("FAIL last_cycle_drop: rd=%0h want 607", cpu_rd_data); end
      wr(A_PTR, 12'h010);
      n_cmp++; if (cpu_rd_data !== 12'h410) begin n_bad++; $display("FAIL first_accept: rd=%0h want 410", cpu_rd_data); end
   endtask

   task automatic test_fill_bounds;
      int cnt;
      wr(A_PTR, 12'h3FE);
      wr(A_FILL, 12'd0);
      n_cmp++;
      if ({busy, pf_write} !== 2'b00) begin n_bad++; $display("FAIL fill0: busy=%0b pfw=%0b want 0 0", busy, pf_write); end
      n_cmp++; if (cpu_rd_data !== 12'h3FE) begin n_bad++; $display("FAIL fill0_rd: rd=%0h want 3fe", cpu_rd_data); end
      for (int i = 0; i < 1024; i++) push(10'(10'h3FE + i), 8'h05);
      wr(A_FILL, 12'h7FF);
      cnt = 0;
      while (busy === 1'b1 && cnt < 1200) begin
         cnt++;
         @(negedge i_Clk);
      end
      n_cmp++; if (cnt != 1024) begin n_bad++; $display("FAIL fill_max_len: busy cycles=%0d want 1024", cnt); end
      n_cmp++; if (cpu_rd_data !== 12'h3FE) begin n_bad++; $display("FAIL fill_max_ptr: rd=%0h want 3fe", cpu_rd_data); end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL fill_max_left: pending=%0d want 0", exp_q.size()); end
   endtask

   task automatic test_unselected;
      wr(12'h400, 12'h055);
      wr(12'h401, 12'h099);
      n_cmp++; if (pf_write !== 1'b0) begin n_bad++; $display("FAIL unsel_pfw: pfw=%0b want 0", pf_write); end
      cpu_addr = 12'h400; #1;
      n_cmp++; if (cpu_rd_data !== 12'h000) begin n_bad++; $display("FAIL unsel_rd: rd=%0h want 000", cpu_rd_data); end
      cpu_addr = A_PTR; #1;
      n_cmp++; if (cpu_rd_data !== 12'h3FE) begin n_bad++; $display("FAIL unsel_ptr: rd=%0h want 3fe", cpu_rd_data); end
      @(negedge i_Clk);
   endtask

   task automatic test_reset_mid_fill;
      wr(A_PTR, 12'h000);
      for (int i = 0; i < 1024; i++) push(10'(i), 8'h05);
      wr(A_FILL, 12'h400);
      repeat (10) @(negedge i_Clk);
      #2 i_Reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({pf_write, busy, cpu_rd_data} !== 14'h0) begin
         n_bad++; $display("FAIL reset_async: pfw=%0b busy=%0b rd=%0h want 0 0 0", pf_write, busy, cpu_rd_data);
      end
      exp_q.delete();
      @(negedge i_Clk);
      i_Reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge i_Clk);
         n_cmp++;
         if ({pf_write, busy} !== 2'b00) begin
            n_bad++; $display("FAIL after_reset[%0d]: pfw=%0b busy=%0b want 0 0", i, pf_write, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_fill();
      test_busy_drop();
      test_fill_bounds();
      test_unselected();
      test_reset_mid_fill();
      n_cmp++;
      if (exp_q.size() != 0) begin n_bad++; $display("FAIL sb_drain: pending=%0d want 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
